// File: rtl/rotate_right_seq_pkg.sv
// Shared constants and state encoding for the sequential rotate-right unit.
package rotate_right_seq_pkg;

    localparam int unsigned ROR_WIDTH  = 32;
    localparam int unsigned ROR_STAGES = 5;
    // Stage counter width; must hold 0..ROR_STAGES-1.
    localparam int unsigned ROR_KW     = 3;

    typedef enum logic {
        ROR_IDLE = 1'b0,
        ROR_RUN  = 1'b1
    } ror_state_e;

endpackage

// File: rtl/rotr_stage.sv
// One logarithmic rotate stage: rotates right by 2^k when enabled, else passes through.
module rotr_stage
    import rotate_right_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ROR_WIDTH
) (
    input  logic [WIDTH-1:0]  in,
    input  logic              en,
    input  logic [ROR_KW-1:0] k,
    output logic [WIDTH-1:0]  out
);

    logic [2*WIDTH-1:0] dbl;

    always_comb begin
        // Shifting the doubled word turns a rotate into a plain shift.
        dbl = {in, in} >> (1 << k);
        out = en ? dbl[WIDTH-1:0] : in;
    end

endmodule

// File: rtl/rotate_right_seq.sv
// Multi-cycle rotate-right: one logarithmic stage per clock, done strobe on completion.
module rotate_right_seq
    import rotate_right_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ROR_WIDTH,
    parameter int unsigned LOG2W = ROR_STAGES
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done
);

    ror_state_e        state_q, state_d;
    logic [ROR_KW-1:0] k_q, k_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [LOG2W-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  stage_out;

    // Only B mod WIDTH matters.
    logic unused_b;
    assign unused_b = ^B[WIDTH-1:LOG2W];

    rotr_stage #(
        .WIDTH(WIDTH)
    ) u_stage (
        .in (work_q),
        .en (m_q[k_q]),
        .k  (k_q),
        .out(stage_out)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        m_d     = m_q;
        r_d     = r_q;
        done_d  = 1'b0;
        unique case (state_q)
            ROR_IDLE: begin
                if (start) begin
                    work_d  = A;
                    m_d     = B[LOG2W-1:0];
                    k_d     = '0;
                    state_d = ROR_RUN;
                end
            end
            ROR_RUN: begin
                work_d = stage_out;
                k_d    = k_q + 1'b1;
                if (k_q == ROR_KW'(LOG2W - 1)) begin
                    r_d     = stage_out;
                    done_d  = 1'b1;
                    k_d     = '0;
                    state_d = ROR_IDLE;
                end
            end
            default: state_d = ROR_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ROR_IDLE;
            k_q     <= '0;
            work_q  <= '0;
            m_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            m_q     <= m_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    assign R    = r_q;
    assign busy = (state_q == ROR_RUN);
    assign done = done_q;

endmodule
